// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register-file write-back arbiter.
package regfile_pkg;

    localparam int unsigned RF_BUS_WIDTH = 8;
    localparam int unsigned RF_DEPTH     = 8;
    localparam int unsigned RF_AW        = $clog2(RF_DEPTH);

    // Arbiter priority: ALU by default, LSU for one cycle after starvation.
    typedef enum logic [0:0] {
        ARB_ALU = 1'b0,
        ARB_LSU = 1'b1
    } arb_state_t;

    // One write-back request as it travels to the register-file write port.
    typedef struct packed {
        logic [RF_AW-1:0]        addr;
        logic [RF_BUS_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_bypass.sv
// Read-port staleness correction: the register file returns the old value
// when a read and a write hit the same address in one cycle; this block
// remembers that collision and substitutes the written data a cycle later.
module rf_bypass
    import regfile_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = RF_BUS_WIDTH,
    parameter int unsigned AW        = RF_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rf_we,
    input  logic [AW-1:0]        rf_wr_addr,
    input  logic [BUS_WIDTH-1:0] rf_wr_data,
    input  logic [AW-1:0]        rd_addr,
    input  logic [BUS_WIDTH-1:0] rf_rd_data,
    output logic [BUS_WIDTH-1:0] rd_data
);

    logic                 hit_q, hit_d;
    logic [BUS_WIDTH-1:0] byp_q, byp_d;

    // Detect a write landing on the address being read this cycle.
    always_comb begin
        hit_d = rf_we && (rf_wr_addr == rd_addr);
        byp_d = rf_wr_data;
    end

    // Hold the collision flag and the written data for the read's return cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= 1'b0;
            byp_q <= '0;
        end else begin
            hit_q <= hit_d;
            byp_q <= byp_d;
        end
    end

    // Substitute the fresh value when the raw read is stale.
    assign rd_data = hit_q ? byp_q : rf_rd_data;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between the ALU and LSU
// write-back streams (ALU priority, LSU starvation guard), registers the
// granted write, and bypass-corrects both read ports.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter  int unsigned BUS_WIDTH = RF_BUS_WIDTH,
    parameter  int unsigned DEPTH     = RF_DEPTH,
    parameter  int unsigned MAX_WAIT  = 3,
    parameter  int unsigned ZERO_REG  = 1,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [AW-1:0]        alu_addr,
    input  logic [BUS_WIDTH-1:0] alu_data,

    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [AW-1:0]        lsu_addr,
    input  logic [BUS_WIDTH-1:0] lsu_data,

    output logic                 rf_we,
    output logic [AW-1:0]        rf_wr_addr,
    output logic [BUS_WIDTH-1:0] rf_wr_data,

    input  logic [AW-1:0]        rd_addr_a,
    input  logic [AW-1:0]        rd_addr_b,
    input  logic [BUS_WIDTH-1:0] rf_rd_data_a,
    input  logic [BUS_WIDTH-1:0] rf_rd_data_b,
    output logic [BUS_WIDTH-1:0] rd_data_a,
    output logic [BUS_WIDTH-1:0] rd_data_b
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    arb_state_t     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           alu_hs, lsu_hs, any_hs;
    wb_req_t        req_sel;
    wb_req_t        wr_req_q, wr_req_d;
    logic           wr_we_q, wr_we_d;

    // Arbiter state and LSU starvation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_ALU;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next arbiter state: count LSU losses, hand LSU one priority cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_ALU: begin
                if (lsu_valid && !lsu_ready) begin
                    if (cnt_q == CW'(MAX_WAIT - 1)) begin
                        state_d = ARB_LSU;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (lsu_hs) begin
                    cnt_d = '0;
                end
            end
            ARB_LSU: begin
                // LSU either handshakes or is idle here; priority lasts one cycle.
                state_d = ARB_ALU;
                cnt_d   = '0;
            end
            default: begin
                state_d = ARB_ALU;
                cnt_d   = '0;
            end
        endcase
    end

    // Ready outputs: depend only on state and valids, forced low in reset.
    always_comb begin
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                ARB_ALU: begin
                    alu_ready = 1'b1;
                    lsu_ready = !alu_valid;
                end
                ARB_LSU: begin
                    lsu_ready = 1'b1;
                    alu_ready = !lsu_valid;
                end
                default: begin
                    alu_ready = 1'b0;
                    lsu_ready = 1'b0;
                end
            endcase
        end
    end

    assign alu_hs = alu_valid && alu_ready;
    assign lsu_hs = lsu_valid && lsu_ready;
    assign any_hs = alu_hs || lsu_hs;

    // Select the granted request and decide whether it really writes.
    always_comb begin
        req_sel.addr = RF_AW'(alu_addr);
        req_sel.data = RF_BUS_WIDTH'(alu_data);
        if (lsu_hs) begin
            req_sel.addr = RF_AW'(lsu_addr);
            req_sel.data = RF_BUS_WIDTH'(lsu_data);
        end

        wr_req_d = wr_req_q;
        wr_we_d  = 1'b0;
        if (any_hs) begin
            wr_req_d = req_sel;
            // Register 0 is hard-wired: accept the write but never commit it.
            wr_we_d  = !((ZERO_REG != 0) && (req_sel.addr == '0));
        end
    end

    // Write-port register feeding the register file one cycle after handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_we_q  <= 1'b0;
            wr_req_q <= '0;
        end else begin
            wr_we_q  <= wr_we_d;
            wr_req_q <= wr_req_d;
        end
    end

    assign rf_we      = wr_we_q;
    assign rf_wr_addr = AW'(wr_req_q.addr);
    assign rf_wr_data = BUS_WIDTH'(wr_req_q.data);

    // Read port A staleness correction.
    rf_bypass #(
        .BUS_WIDTH (BUS_WIDTH),
        .AW        (AW)
    ) u_byp_a (
        .clk        (clk),
        .rst        (rst),
        .rf_we      (rf_we),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .rd_addr    (rd_addr_a),
        .rf_rd_data (rf_rd_data_a),
        .rd_data    (rd_data_a)
    );

    // Read port B staleness correction.
    rf_bypass #(
        .BUS_WIDTH (BUS_WIDTH),
        .AW        (AW)
    ) u_byp_b (
        .clk        (clk),
        .rst        (rst),
        .rf_we      (rf_we),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .rd_addr    (rd_addr_b),
        .rf_rd_data (rf_rd_data_b),
        .rd_data    (rd_data_b)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter with a behavioural
// register file attached to the write and read ports.
module tb_regfile_wb_arbiter;

    localparam int unsigned BW       = 8;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned AW       = 3;
    localparam int unsigned MAX_WAIT = 3;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
    } wr_exp_t;

    typedef struct packed {
        logic [BW-1:0] a;
        logic [BW-1:0] b;
    } rd_exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [AW-1:0] alu_addr, lsu_addr;
    logic [BW-1:0] alu_data, lsu_data;
    logic          rf_we;
    logic [AW-1:0] rf_wr_addr;
    logic [BW-1:0] rf_wr_data;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic [BW-1:0] rf_rd_data_a, rf_rd_data_b, rd_data_a, rd_data_b;

    logic          mem_init;
    logic [BW-1:0] rf_mem [DEPTH];

    int total = 0;
    int bad   = 0;

    wr_exp_t wq[$];
    rd_exp_t rq[$];

    // Reference-model state
    logic [BW-1:0] exp_regs [DEPTH];
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_data;
    bit            lsu_turn;
    int            losses;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .BUS_WIDTH (BW),
        .DEPTH     (DEPTH),
        .MAX_WAIT  (MAX_WAIT),
        .ZERO_REG  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_addr     (lsu_addr),
        .lsu_data     (lsu_data),
        .rf_we        (rf_we),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rf_rd_data_a (rf_rd_data_a),
        .rf_rd_data_b (rf_rd_data_b),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b)
    );

    // Behavioural register file: 1-cycle read, write commits at end of cycle,
    // a same-cycle read of the written address returns the old value.
    always @(posedge clk) begin
        rf_rd_data_a <= rf_mem[rd_addr_a];
        rf_rd_data_b <= rf_mem[rd_addr_b];
        if (mem_init) begin
            for (int i = 0; i < int'(DEPTH); i++) rf_mem[i] <= BW'(i * 17);
        end else if (rf_we) begin
            rf_mem[rf_wr_addr] <= rf_wr_data;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: evaluates each cycle's inputs after they settle.
    initial begin
        logic          e_ar, e_lr, aw, lw;
        logic [BW-1:0] pre_a, pre_b;
        wr_exp_t       nw;
        rd_exp_t       nr;
        for (int i = 0; i < int'(DEPTH); i++) exp_regs[i] = BW'(i * 17);
        m_we = 1'b0; m_addr = '0; m_data = '0;
        lsu_turn = 1'b0; losses = 0;
        forever begin
            @(negedge clk); #1;
            // Readiness: ALU favoured unless the LSU has earned its turn.
            if (rst) begin
                e_ar = 1'b0; e_lr = 1'b0;
            end else if (lsu_turn) begin
                e_lr = 1'b1; e_ar = !lsu_valid;
            end else begin
                e_ar = 1'b1; e_lr = !alu_valid;
            end
            check("alu_ready", 32'(alu_ready), 32'(e_ar));
            check("lsu_ready", 32'(lsu_ready), 32'(e_lr));

            aw = !rst && alu_valid && (!lsu_turn || !lsu_valid);
            lw = !rst && lsu_valid && !aw;

            // Architectural read value: includes this cycle's write unless reset.
            pre_a = exp_regs[rd_addr_a];
            pre_b = exp_regs[rd_addr_b];
            if (m_we) exp_regs[m_addr] = m_data;
            nr.a = rst ? pre_a : exp_regs[rd_addr_a];
            nr.b = rst ? pre_b : exp_regs[rd_addr_b];
            if (!mem_init) rq.push_back(nr);

            if (rst) begin
                nw = '0;
            end else if (aw) begin
                nw.we = (alu_addr != 0); nw.addr = alu_addr; nw.data = alu_data;
            end else if (lw) begin
                nw.we = (lsu_addr != 0); nw.addr = lsu_addr; nw.data = lsu_data;
            end else begin
                nw.we = 1'b0; nw.addr = m_addr; nw.data = m_data;
            end
            wq.push_back(nw);
            m_we = nw.we; m_addr = nw.addr; m_data = nw.data;

            // Starvation bookkeeping.
            if (rst || lsu_turn) begin
                lsu_turn = 1'b0; losses = 0;
            end else if (lsu_valid && !lw) begin
                losses++;
                if (losses == int'(MAX_WAIT)) begin
                    lsu_turn = 1'b1; losses = 0;
                end
            end else if (lw) begin
                losses = 0;
            end
        end
    end

    // Monitor: compares each cycle's write port and corrected read data.
    always @(negedge clk) begin
        wr_exp_t w;
        rd_exp_t r;
        if (wq.size() > 0) begin
            w = wq.pop_front();
            check("rf_we",      32'(rf_we),      32'(w.we));
            check("rf_wr_addr", 32'(rf_wr_addr), 32'(w.addr));
            check("rf_wr_data", 32'(rf_wr_data), 32'(w.data));
        end
        if (rq.size() > 0) begin
            r = rq.pop_front();
            check("rd_data_a", 32'(rd_data_a), 32'(r.a));
            check("rd_data_b", 32'(rd_data_b), 32'(r.b));
        end
    end

    task automatic drive_cycle(input int pa, input int pl, input int prst);
        @(posedge clk); #1;
        rst       = (int'($urandom_range(99)) < prst);
        alu_valid = (int'($urandom_range(99)) < pa);
        lsu_valid = (int'($urandom_range(99)) < pl);
        alu_addr  = ($urandom_range(5) == 0) ? AW'(0) : AW'($urandom_range(7));
        lsu_addr  = ($urandom_range(5) == 0) ? AW'(0) : AW'($urandom_range(7));
        alu_data  = BW'($urandom);
        lsu_data  = BW'($urandom);
        rd_addr_a = ($urandom_range(1) == 1) ? m_addr : AW'($urandom_range(7));
        rd_addr_b = ($urandom_range(2) == 0) ? m_addr : AW'($urandom_range(7));
    endtask

    // Stimulus
    initial begin
        int levels [4];
        levels[0] = 20; levels[1] = 50; levels[2] = 80; levels[3] = 100;
        rst = 1'b1; mem_init = 1'b1;
        alu_valid = 1'b1; lsu_valid = 1'b1;
        alu_addr = 3'd1; lsu_addr = 3'd2;
        alu_data = 8'h11; lsu_data = 8'h22;
        rd_addr_a = '0; rd_addr_b = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_init = 1'b0;

        // ALU alone
        for (int i = 0; i < 20; i++) drive_cycle(60, 0, 0);
        // Sustained contention
        for (int i = 0; i < 16; i++) drive_cycle(100, 100, 0);
        // Mixed random load with occasional mid-operation reset
        for (int s = 0; s < 16; s++) begin
            int pa, pl;
            pa = levels[$urandom_range(3)];
            pl = levels[$urandom_range(3)];
            for (int i = 0; i < 25; i++) drive_cycle(pa, pl, 3);
        end
        // LSU alone
        for (int i = 0; i < 20; i++) drive_cycle(0, 70, 0);
        // Drain
        for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0);
        @(posedge clk); #2;

        if (total < 1000) begin
            bad++;
            $display("FAIL check_count: got %0d expected at least 1000", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and read-bypass controller for the CPU register file, which has one synchronous write port and two synchronous read ports. It shares the single write port between the ALU and LSU write-back streams using valid/ready handshakes. It uses fixed ALU priority with a starvation guard for the LSU and registers the granted write into the register-file write port. It also corrects both read ports for same-cycle write-then-read staleness.

## Interface
- BUS_WIDTH, 8: register data width.
- DEPTH, 8: number of registers; AW = $clog2(DEPTH).
- MAX_WAIT, 3: consecutive LSU losses before LSU gets priority; must be ≥1.
- ZERO_REG, 1: when 1, writes to address 0 are accepted but never reach the register file.

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- rst  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU write-back request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_addr  in  AW  ALU destination register.
- alu_data  in  BUS_WIDTH  ALU result.
- lsu_valid, lsu_ready, lsu_addr, lsu_data: LSU equivalents of the four ALU ports, same directions and widths.
- rf_we  out  1  register-file write enable.
- rf_wr_addr  out  AW  register-file write address.
- rf_wr_data  out  BUS_WIDTH  register-file write data.
- rd_addr_a, rd_addr_b  in  AW  read addresses, also driven to the register file.
- rf_rd_data_a, rf_rd_data_b  in  BUS_WIDTH  raw registered read data from the register file.
- rd_data_a, rd_data_b  out  BUS_WIDTH  bypass-corrected read data.

## Operation
- A handshake occurs when valid && ready. At most one handshake occurs per cycle.
- FSM states are ARB_ALU (reset state) and ARB_LSU.
- In ARB_ALU:
  - alu_ready = 1.
  - lsu_ready = !alu_valid.
- In ARB_LSU:
  - lsu_ready = 1.
  - alu_ready = !lsu_valid.
- During rst, alu_ready = lsu_ready = 0.
- Ready signals are combinational from state and valids. They never depend on the addr or data inputs.
- Wait counter (width $clog2(MAX_WAIT+1), reset value 0):
  - In ARB_ALU, a cycle with lsu_valid && !lsu_ready increments the counter.
  - If that loss happens with counter == MAX_WAIT-1, the next state is ARB_LSU and the counter returns to 0.
  - Any LSU handshake clears the counter.
- ARB_LSU → ARB_ALU on an LSU handshake or when lsu_valid is low. The FSM spends exactly one cycle in ARB_LSU.
- Write register: a handshake latches addr/data, and rf_we = 1 in the following cycle. With no handshake, rf_we = 0 in the following cycle and addr/data hold their previous values.
- If ZERO_REG = 1 and the accepted addr is 0, the handshake still completes but rf_we = 0.
- Bypass, for each port x ∈ {a, b}:
  - At every edge, register hit_x = rf_we && (rf_wr_addr == rd_addr_x), and register byp_x = rf_wr_data.
  - rd_data_x = hit_x ? byp_x : rf_rd_data_x, combinational from registered state.

## Timing
- Write latency: a handshake in cycle t gives rf_we/rf_wr_addr/rf_wr_data in cycle t+1. The register file commits the write at the end of t+1.
- Read path: an address presented in cycle t gives corrected rd_data_x in cycle t+1. This matches the register file's 1-cycle read latency.
- Same-cycle write and read of one address: the register file returns the old value. The bypass must return the new value in the next cycle.
- Reset values:
  - rf_we = 0, rf_wr_addr = 0, rf_wr_data = 0.
  - hit_a = hit_b = 0, byp_a = byp_b = 0.
  - state = ARB_ALU, counter = 0.
- rd_data_x follows rf_rd_data_x after reset.
- Reset mid-operation: rst wins over a same-cycle handshake. The write is dropped and rf_we = 0 in the next cycle.
- Back-to-back: a new handshake is allowed in every cycle, so sustained throughput is 1 write/cycle.

## Structure
- Package regfile_pkg holds:
  - arb_state_t enum {ARB_ALU, ARB_LSU}.
  - A wb_req_t struct {addr, data}, parameterised via package localparams RF_BUS_WIDTH and RF_DEPTH. Block parameters default to these.
- Sub-module rf_bypass handles one read port: hit/byp registers plus the output mux. It is instantiated twice, for ports a and b.

## Test plan
All scenarios use BUS_WIDTH=8, DEPTH=8, MAX_WAIT=3, ZERO_REG=1.

- Reset: hold rst 2 cycles with both valids high → both readies 0 and rf_we = 0. After release, alu_ready = 1 and lsu_ready = 0.
- ALU alone: alu_valid with addr 3, data 0x5A in cycle t → alu_ready = 1 in t; in t+1, rf_we = 1, rf_wr_addr = 3, rf_wr_data = 0x5A; in t+2, rf_we = 0.
- Contention: both valid continuously from cycle 0 →
  - ALU wins cycles 0–2.
  - Cycle 3: lsu_ready = 1, alu_ready = 0.
  - Cycles 4–6: ALU wins again.
  - Cycle 7: LSU wins.
- Zero register: alu addr 0, data 0xFF → handshake completes and rf_we stays 0.
- Bypass: in cycle t, rf_we = 1 with addr 5, data 0x3C; rd_addr_a = 5, rd_addr_b = 4. In t+1, the register file returns 0x00 and 0x11 → rd_data_a = 0x3C, rd_data_b = 0x11.
- Reset mid-operation: ALU handshake (addr 2, data 0x77) in the same cycle as rst=1 → rf_we = 0 in the next cycle, state ARB_ALU, counter 0.
